sample_scheduler: RTL and testbench

//  Bounding-box sample scheduler that sits directly upstream of sampletest.

---
 rtl/sample_scheduler.sv | 168 ++++++++++++++++
 tb/tb_sample_scheduler.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sample_scheduler.sv
// Bounding-box sample scheduler.
// Latches one triangle and its bounding box, then walks the box in raster
// order (x fastest), issuing SAMPS horizontally adjacent sample positions per
// beat. Upstream is held off while a triangle is in flight, and the whole
// block freezes while downstream stalls (halt_RnnnnnL = 0).
module sample_scheduler #(
    parameter int SIGFIG = 24,
    parameter int RADIX  = 10,
    parameter int VERTS  = 3,
    parameter int AXIS   = 3,
    parameter int COLORS = 3,
    parameter int SAMPS  = 4
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic [VERTS-1:0][AXIS-1:0][SIGFIG-1:0] tri_R13S,
    input  logic [COLORS-1:0][SIGFIG-1:0]         color_R13U,
    input  logic [1:0][1:0][SIGFIG-1:0]           box_R13S,
    input  logic                                  validTri_R13H,
    input  logic [3:0]                            subSample_RnnnnU,
    input  logic                                  halt_RnnnnnL,
    output logic                                  halt_R13L,
    output logic [VERTS-1:0][AXIS-1:0][SIGFIG-1:0] tri_R14S,
    output logic [COLORS-1:0][SIGFIG-1:0]         color_R14U,
    output logic [1:0][SAMPS-1:0][SIGFIG-1:0]     sample_R14S,
    output logic [SAMPS-1:0]                      validSamp_R14H
);

    // One guard bit above the coordinate width keeps every increment from wrapping.
    localparam int CW         = SIGFIG + 1;
    localparam int LANE_SHIFT = $clog2(SAMPS);

    typedef logic signed [CW-1:0] coord_t;
    typedef enum logic {IDLE, TEST} state_t;

    state_t state, state_next;

    // Walk registers: current beat origin, row restart x, and box upper-right.
    coord_t step_r, cur_x, cur_y, ll_x, ur_x, ur_y;

    // Incoming box, sign-extended and snapped.
    coord_t step_in, ll_x_raw, ll_y_raw, ur_x_raw, ur_y_raw, ll_x_snap, ll_y_snap;
    logic   box_empty;

    // Walk arithmetic for the beat being issued.
    coord_t lane_x [SAMPS];
    coord_t next_x, next_y;
    logic   more_cols, more_rows;

    logic accept, issue;

    // Decode the sub-sample code into a step; anything not one-hot falls back to 1 px.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        step_in = coord_t'(1) << RADIX;
        case (subSample_RnnnnU)
            4'b0100: step_in = coord_t'(1) << (RADIX - 1);
            4'b0010: step_in = coord_t'(1) << (RADIX - 2);
            4'b0001: step_in = coord_t'(1) << (RADIX - 3);
            default: step_in = coord_t'(1) << RADIX;
        endcase
    end

    // Sign-extend the box, snap lower-left down to a step multiple, detect an empty box.
    always_comb begin
        ll_x_raw  = coord_t'($signed(box_R13S[0][0]));
        ll_y_raw  = coord_t'($signed(box_R13S[0][1]));
        ur_x_raw  = coord_t'($signed(box_R13S[1][0]));
        ur_y_raw  = coord_t'($signed(box_R13S[1][1]));
        ll_x_snap = ll_x_raw & ~(step_in - coord_t'(1));
        ll_y_snap = ll_y_raw & ~(step_in - coord_t'(1));
        box_empty = (ll_x_snap > ur_x_raw) || (ll_y_snap > ur_y_raw);
    end

    // Lane positions for this beat and the raster-advance decisions.
    always_comb begin
        for (int s = 0; s < SAMPS; s++) begin
            lane_x[s] = cur_x + coord_t'(s) * step_r;
        end
        next_x    = cur_x + (step_r << LANE_SHIFT);
        next_y    = cur_y + step_r;
        more_cols = (next_x <= ur_x);
        more_rows = (next_y <= ur_y);
    end

    // State register.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and handshake decode. A downstream stall freezes everything,
    // including acceptance; upstream keeps its triangle presented until taken.
    always_comb begin
        state_next = state;
        accept     = 1'b0;
        issue      = 1'b0;
        halt_R13L  = 1'b0;
        case (state)
            IDLE: begin
                halt_R13L = 1'b1;
                if (halt_RnnnnnL && validTri_R13H) begin
                    accept = 1'b1;
                    if (!box_empty) begin
                        state_next = TEST;
                    end
                end
            end
            TEST: begin
                if (halt_RnnnnnL) begin
                    issue = 1'b1;
                    if (!more_cols && !more_rows) begin
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Capture on accept, issue one beat per unstalled TEST cycle, clear lanes when idle.
    always_ff @(posedge clk) begin
        if (rst) begin
            step_r         <= '0;
            cur_x          <= '0;
            cur_y          <= '0;
            ll_x           <= '0;
            ur_x           <= '0;
            ur_y           <= '0;
            tri_R14S       <= '0;
            color_R14U     <= '0;
            sample_R14S    <= '0;
            validSamp_R14H <= '0;
        end else if (halt_RnnnnnL) begin
            if (state == IDLE) begin
                validSamp_R14H <= '0;
            end
            if (accept) begin
                tri_R14S   <= tri_R13S;
                color_R14U <= color_R13U;
                step_r     <= step_in;
                ll_x       <= ll_x_snap;
                cur_x      <= ll_x_snap;
                cur_y      <= ll_y_snap;
                ur_x       <= ur_x_raw;
                ur_y       <= ur_y_raw;
            end
            if (issue) begin
                for (int s = 0; s < SAMPS; s++) begin
                    sample_R14S[0][s]    <= lane_x[s][SIGFIG-1:0];
                    sample_R14S[1][s]    <= cur_y[SIGFIG-1:0];
                    validSamp_R14H[s]    <= (lane_x[s] <= ur_x);
                end
                if (more_cols) begin
                    cur_x <= next_x;
                end else if (more_rows) begin
                    cur_x <= ll_x;
                    cur_y <= next_y;
                end
            end
        end
    end

endmodule

// File: tb/tb_sample_scheduler.sv
// Testbench for sample_scheduler: directed corner cases plus randomized
// triangles with random downstream stalls, checked through a beat scoreboard.
module tb_sample_scheduler;

    localparam int SIGFIG = 24;
    localparam int RADIX  = 10;
    localparam int VERTS  = 3;
    localparam int AXIS   = 3;
    localparam int COLORS = 3;
    localparam int SAMPS  = 4;

    typedef logic [VERTS-1:0][AXIS-1:0][SIGFIG-1:0] tri_t;
    typedef logic [COLORS-1:0][SIGFIG-1:0]          col_t;
    typedef logic [1:0][SAMPS-1:0][SIGFIG-1:0]      samp_t;

    typedef struct {
        samp_t            samp;
        logic [SAMPS-1:0] vld;
        tri_t             tri_v;
        col_t             col;
    } beat_t;

    logic                           clk = 1'b0;
    logic                           rst;
    tri_t                           tri_R13S;
    col_t                           color_R13U;
    logic [1:0][1:0][SIGFIG-1:0]    box_R13S;
    logic                           validTri_R13H;
    logic [3:0]                     subSample_RnnnnU;
    logic                           halt_RnnnnnL;
    logic                           halt_R13L;
    tri_t                           tri_R14S;
    col_t                           color_R14U;
    samp_t                          sample_R14S;
    logic [SAMPS-1:0]               validSamp_R14H;

    beat_t exp_q[$];
    int    checks = 0;
    int    errors = 0;
    bit    rand_stall = 1'b0;

    sample_scheduler #(
        .SIGFIG(SIGFIG), .RADIX(RADIX), .VERTS(VERTS),
        .AXIS(AXIS), .COLORS(COLORS), .SAMPS(SAMPS)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .tri_R13S         (tri_R13S),
        .color_R13U       (color_R13U),
        .box_R13S         (box_R13S),
        .validTri_R13H    (validTri_R13H),
        .subSample_RnnnnU (subSample_RnnnnU),
        .halt_RnnnnnL     (halt_RnnnnnL),
        .halt_R13L        (halt_R13L),
        .tri_R14S         (tri_R14S),
        .color_R14U       (color_R14U),
        .sample_R14S      (sample_R14S),
        .validSamp_R14H   (validSamp_R14H)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // Reference model: enumerate the snapped box row by row, SAMPS columns per beat.
    function automatic void model_tri(input logic [3:0] sub, input longint llx, input longint lly,
                                      input longint urx, input longint ury,
                                      input tri_t t, input col_t c);
        longint step, sx, sy, x, y, x0;
        beat_t  b;
        case (sub)
            4'b0100: step = (longint'(1) << RADIX) / 2;
            4'b0010: step = (longint'(1) << RADIX) / 4;
            4'b0001: step = (longint'(1) << RADIX) / 8;
            default: step = longint'(1) << RADIX;
        endcase
        sx = llx - (((llx % step) + step) % step);
        sy = lly - (((lly % step) + step) % step);
        if (sx > urx || sy > ury) return;
        for (y = sy; y <= ury; y += step) begin
            for (x0 = sx; x0 <= urx; x0 += SAMPS * step) begin
                for (int s = 0; s < SAMPS; s++) begin
                    x = x0 + s * step;
                    b.samp[0][s] = SIGFIG'(x);
                    b.samp[1][s] = SIGFIG'(y);
                    b.vld[s]     = (x <= urx);
                end
                b.tri_v = t;
                b.col   = c;
                exp_q.push_back(b);
            end
        end
    endfunction

    task automatic randomize_inputs();
        for (int v = 0; v < VERTS; v++)
            for (int a = 0; a < AXIS; a++)
                tri_R13S[v][a] = SIGFIG'($urandom);
        for (int k = 0; k < COLORS; k++) color_R13U[k] = SIGFIG'($urandom);
        for (int k = 0; k < 2; k++)
            for (int a = 0; a < 2; a++)
                box_R13S[k][a] = SIGFIG'($urandom);
        validTri_R13H    = 1'($urandom);
        subSample_RnnnnU = 4'($urandom);
        halt_RnnnnnL     = 1'($urandom);
    endtask

    // Present a triangle (called just after a rising edge); returns just after the accepting edge.
    task automatic send_tri(input logic [3:0] sub, input longint llx, input longint lly,
                            input longint urx, input longint ury);
        tri_t t;
        col_t c;
        bit   done = 1'b0;
        for (int v = 0; v < VERTS; v++)
            for (int a = 0; a < AXIS; a++)
                t[v][a] = SIGFIG'($urandom);
        for (int k = 0; k < COLORS; k++) c[k] = SIGFIG'($urandom);
        tri_R13S         = t;
        color_R13U       = c;
        subSample_RnnnnU = sub;
        box_R13S[0][0]   = SIGFIG'(llx);
        box_R13S[0][1]   = SIGFIG'(lly);
        box_R13S[1][0]   = SIGFIG'(urx);
        box_R13S[1][1]   = SIGFIG'(ury);
        validTri_R13H    = 1'b1;
        for (int i = 0; i < 2000 && !done; i++) begin
            @(negedge clk);
            if (halt_R13L && halt_RnnnnnL && !rst) begin
                model_tri(sub, llx, lly, urx, ury, t, c);
                done = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        validTri_R13H = 1'b0;
        check("accepted", 256'(done), 256'(1));
    endtask

    // Wait until every expected beat has been consumed and the block is idle.
    task automatic drain();
        int n = 0;
        while ((exp_q.size() != 0 || !halt_R13L) && n < 5000) begin
            @(negedge clk);
            n++;
        end
        check("drain_queue_empty", 256'(exp_q.size()), 256'(0));
        @(posedge clk);
        #1;
    endtask

    // Downstream stall generator for the random phase.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rand_stall) halt_RnnnnnL = ($urandom_range(0, 99) >= 30);
        end
    end

    // Monitor: a beat is consumed at an edge where lanes are live and downstream is ready.
    initial begin : monitor
        beat_t b;
        forever begin
            @(negedge clk);
            if (!rst && halt_RnnnnnL && validSamp_R14H != '0) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_beat", 256'(validSamp_R14H), 256'(0));
                end else begin
                    b = exp_q.pop_front();
                    check("beat_samples", 256'(sample_R14S), 256'(b.samp));
                    check("beat_valid", 256'(validSamp_R14H), 256'(b.vld));
                    check("beat_tri", 256'(tri_R14S), 256'(b.tri_v));
                    check("beat_color", 256'(color_R14U), 256'(b.col));
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int       low;
        int       r;
        logic [3:0] sub;
        longint   llx, lly, w, h;

        // Reset with random inputs.
        rst = 1'b1;
        randomize_inputs();
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            #1;
            randomize_inputs();
            @(negedge clk);
            check("reset_halt_up", 256'(halt_R13L), 256'(1));
            check("reset_valid", 256'(validSamp_R14H), 256'(0));
            check("reset_samples", 256'(sample_R14S), 256'(0));
            check("reset_tri", 256'(tri_R14S), 256'(0));
        end
        rst           = 1'b0;
        validTri_R13H = 1'b0;
        halt_RnnnnnL  = 1'b1;
        @(posedge clk);
        #1;

        // 2x4 px box, 1 px step: two full beats, upstream busy for exactly two cycles.
        send_tri(4'b1000, 0, 0, 3 << 10, 1 << 10);
        low = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (halt_R13L) break;
            low++;
        end
        check("busy_cycles", 256'(low), 256'(2));
        drain();

        // Single row, five columns: second beat has one live lane.
        send_tri(4'b1000, 0, 0, 4 << 10, 0);
        drain();

        // Same box as the first case, downstream stalls three cycles after beat 1.
        send_tri(4'b1000, 0, 0, 3 << 10, 1 << 10);
        @(posedge clk);
        #1;
        halt_RnnnnnL = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("stall_hold_valid", 256'(validSamp_R14H), 256'(4'b1111));
            check("stall_hold_y", 256'(sample_R14S[1][0]), 256'(0));
            @(posedge clk);
            #1;
        end
        halt_RnnnnnL = 1'b1;
        drain();

        // Inverted box in x: dropped, nothing issued.
        send_tri(4'b1000, 2048, 0, 1024, 1024);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("empty_halt_up", 256'(halt_R13L), 256'(1));
            check("empty_no_valid", 256'(validSamp_R14H), 256'(0));
        end
        check("empty_no_beats", 256'(exp_q.size()), 256'(0));
        @(posedge clk);
        #1;

        // Half-pixel step, lower-left snapped; reset in the middle of beat 2.
        send_tri(4'b0100, 700, 0, 4000, 1024);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        check("snap_beat2_x", 256'(sample_R14S[0][0]), 256'(2560));
        rst = 1'b1;
        exp_q.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("midreset_valid", 256'(validSamp_R14H), 256'(0));
        check("midreset_halt_up", 256'(halt_R13L), 256'(1));
        check("midreset_samples", 256'(sample_R14S), 256'(0));
        @(posedge clk);
        #1;
        send_tri(4'b0010, -300, -300, 500, 200);
        drain();

        // Extremes of the coordinate range.
        send_tri(4'b1000, 8388607 - 3000, 8388607 - 1500, 8388607, 8388607);
        drain();
        send_tri(4'b0001, -8388608, -8388608 + 5, -8388608 + 900, -8388608 + 300);
        drain();

        // Random triangles, back to back, with random downstream stalls.
        rand_stall = 1'b1;
        for (int n = 0; n < 40; n++) begin
            r = $urandom_range(0, 4);
            case (r)
                0:       sub = 4'b1000;
                1:       sub = 4'b0100;
                2:       sub = 4'b0010;
                3:       sub = 4'b0001;
                default: sub = 4'($urandom);
            endcase
            llx = longint'($urandom_range(0, 40000)) - 20000;
            lly = longint'($urandom_range(0, 40000)) - 20000;
            w   = longint'($urandom_range(0, 7000)) - 1000;
            h   = longint'($urandom_range(0, 2000)) - 500;
            send_tri(sub, llx, lly, llx + w, lly + h);
        end
        rand_stall = 1'b0;
        @(posedge clk);
        #2;
        halt_RnnnnnL = 1'b1;
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
